// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: request/ack handshake on the instruction bus feeding the IF/ID register.
// Optional fetch timeout (abort with bus_err pulse) is compiled in with `define IFETCH_TIMEOUT_EN.
module if_fetch_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stallreq,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] inst_q_r;
    logic [31:0] pc_q_r;
    logic        timeout_s;
    logic        done_s;
    logic [31:0] word_s;
    logic        issue_s;
    logic        release_s;
    logic        capture_s;
    logic        deliver_s;
    logic [31:0] dlv_pc_s;
    logic [31:0] dlv_inst_s;
    logic        unused_s;

    assign unused_s = ^{stall[5:3], stall[0]};

    // A timeout completes the transaction exactly like an ack carrying a NOP word.
    assign done_s = mem_ack | timeout_s;
    assign word_s = mem_ack ? mem_rdata : 32'h0000_0000;

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             waiting_s;

    assign waiting_s = (state_r == ST_BUSY) || (state_r == ST_DISCARD);
    assign timeout_s = waiting_s && !mem_ack && (cnt_r == CNT_LAST);

    // Wait-cycle counter; restarts whenever the transaction ends or no transaction is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!waiting_s || mem_ack || timeout_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // One-cycle bus error pulse on abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout_s;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Next-state, bus control strobes and stall request.
    always_comb begin
        state_s    = state_r;
        issue_s    = 1'b0;
        release_s  = 1'b0;
        capture_s  = 1'b0;
        deliver_s  = 1'b0;
        dlv_pc_s   = pc_q_r;
        dlv_inst_s = inst_q_r;
        stallreq   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stallreq = ce_i;
                if (ce_i && !flush) begin
                    issue_s = 1'b1;
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stallreq = !done_s;
                if (done_s) begin
                    release_s = 1'b1;
                    if (flush) begin
                        state_s = ST_IDLE;
                    end else if (stall[1]) begin
                        capture_s = 1'b1;
                        state_s   = ST_HOLD;
                    end else begin
                        deliver_s  = 1'b1;
                        dlv_pc_s   = mem_addr;
                        dlv_inst_s = word_s;
                        state_s    = ST_IDLE;
                    end
                end else if (flush) begin
                    state_s = ST_DISCARD;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_HOLD: begin
                stallreq = 1'b0;
                if (flush) begin
                    state_s = ST_IDLE;
                end else if (!stall[1]) begin
                    deliver_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                stallreq = 1'b1;
                if (done_s) begin
                    release_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, bus request/address and the word parked across an IF stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0000_0000;
            inst_q_r <= 32'h0000_0000;
            pc_q_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            if (issue_s) begin
                mem_req  <= 1'b1;
                mem_addr <= pc_i;
            end else if (release_s) begin
                mem_req <= 1'b0;
            end
            if (capture_s) begin
                inst_q_r <= word_s;
                pc_q_r   <= mem_addr;
            end
        end
    end

    // IF/ID pipeline register: flush clears, ID stall holds, otherwise deliver or insert a bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_pc    <= 32'h0000_0000;
            id_inst  <= 32'h0000_0000;
            id_valid <= 1'b0;
        end else if (stall[2]) begin
            id_pc    <= id_pc;
            id_inst  <= id_inst;
            id_valid <= id_valid;
        end else if (deliver_s) begin
            id_pc    <= dlv_pc_s;
            id_inst  <= dlv_inst_s;
            id_valid <= 1'b1;
        end else begin
            id_pc    <= 32'h0000_0000;
            id_inst  <= 32'h0000_0000;
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stallreq;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one open request (possibly stale), one parked word, the IF/ID contents.
    bit          m_req;
    bit          m_stale;
    bit          m_parked;
    logic [31:0] m_addr;
    logic [31:0] m_park_pc;
    logic [31:0] m_park_inst;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    bit          m_id_valid;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        ce;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_sreq;
        logic [31:0] e_id_pc;
        logic [31:0] e_id_inst;
        logic        e_id_valid;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .pc_i      (pc_i),
        .ce_i      (ce_i),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stallreq  (stallreq),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .id_valid  (id_valid),
        .bus_err   (bus_err)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_req       = 1'b0;
        m_stale     = 1'b0;
        m_parked    = 1'b0;
        m_addr      = 32'h0;
        m_park_pc   = 32'h0;
        m_park_inst = 32'h0;
        m_id_pc     = 32'h0;
        m_id_inst   = 32'h0;
        m_id_valid  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs applied in the cycle.
    task automatic model_tick();
        bit          dlv   = 1'b0;
        logic [31:0] dpc   = 32'h0;
        logic [31:0] dinst = 32'h0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_req) begin
            if (mem_ack) begin
                m_req = 1'b0;
                if (!m_stale && !flush) begin
                    if (stall[1]) begin
                        m_parked    = 1'b1;
                        m_park_pc   = m_addr;
                        m_park_inst = mem_rdata;
                    end else begin
                        dlv   = 1'b1;
                        dpc   = m_addr;
                        dinst = mem_rdata;
                    end
                end
                m_stale = 1'b0;
            end else if (flush) begin
                m_stale = 1'b1;
            end
        end else if (m_parked) begin
            if (flush) begin
                m_parked = 1'b0;
            end else if (!stall[1]) begin
                dlv      = 1'b1;
                dpc      = m_park_pc;
                dinst    = m_park_inst;
                m_parked = 1'b0;
            end
        end else if (ce_i && !flush) begin
            m_req  = 1'b1;
            m_addr = pc_i;
        end
        if (flush) begin
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
        end else if (stall[2]) begin
            m_id_valid = m_id_valid;
        end else if (dlv) begin
            m_id_pc = dpc; m_id_inst = dinst; m_id_valid = 1'b1;
        end else begin
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
        end
    endtask

    function automatic logic model_stallreq();
        if (m_req) return m_stale ? 1'b1 : !mem_ack;
        if (m_parked) return 1'b0;
        return ce_i;
    endfunction

    task automatic model_check();
        chk1 ("mem_req",  mem_req,  m_req);
        chk32("mem_addr", mem_addr, m_addr);
        chk1 ("stallreq", stallreq, model_stallreq());
        chk32("id_pc",    id_pc,    m_id_pc);
        chk32("id_inst",  id_inst,  m_id_inst);
        chk1 ("id_valid", id_valid, m_id_valid);
        chk1 ("bus_err",  bus_err,  1'b0);
    endtask

    task automatic run_cycle(input bit do_check);
        @(negedge clk);
        if (do_check) model_check();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 6'h0; flush = 1'b0; ce_i = 1'b0;
        pc_i = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        @(posedge clk); model_tick(); #1;
        @(negedge clk);
        chk1 ("reset mem_req",  mem_req,  1'b0);
        chk32("reset mem_addr", mem_addr, 32'h0);
        chk1 ("reset stallreq", stallreq, 1'b0);
        chk32("reset id_pc",    id_pc,    32'h0);
        chk32("reset id_inst",  id_inst,  32'h0);
        chk1 ("reset id_valid", id_valid, 1'b0);
        chk1 ("reset bus_err",  bus_err,  1'b0);
        @(posedge clk); model_tick(); #1;
        rst = 1'b0;
    endtask

    initial begin
        int wait_cnt;
        // stall, flush, ce, pc, ack, rdata | req, addr, stallreq, id_pc, id_inst, id_valid
        vecs[0]  = '{6'd0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'h0,  32'h0,        1'b0};
        vecs[1]  = '{6'd0, 1'b0, 1'b1, 32'h0,   1'b1, 32'h3401_0020, 1'b1, 32'h0,  1'b0, 32'h0,  32'h0,        1'b0};
        vecs[2]  = '{6'd0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,  32'h3401_0020, 1'b1};
        vecs[3]  = '{6'd0, 1'b0, 1'b1, 32'h40,  1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'h0,  32'h0,        1'b0};
        vecs[4]  = '{6'd6, 1'b0, 1'b1, 32'h40,  1'b1, 32'h1111_2222, 1'b1, 32'h40, 1'b0, 32'h0,  32'h0,        1'b0};
        vecs[5]  = '{6'd6, 1'b0, 1'b1, 32'h44,  1'b0, 32'h0,        1'b0, 32'h40, 1'b0, 32'h0,  32'h0,        1'b0};
        vecs[6]  = '{6'd0, 1'b0, 1'b1, 32'h44,  1'b0, 32'h0,        1'b0, 32'h40, 1'b0, 32'h0,  32'h0,        1'b0};
        vecs[7]  = '{6'd0, 1'b0, 1'b1, 32'h80,  1'b0, 32'h0,        1'b0, 32'h40, 1'b1, 32'h40, 32'h1111_2222, 1'b1};
        vecs[8]  = '{6'd0, 1'b1, 1'b1, 32'h80,  1'b0, 32'h0,        1'b1, 32'h80, 1'b1, 32'h0,  32'h0,        1'b0};
        vecs[9]  = '{6'd0, 1'b0, 1'b1, 32'hC0,  1'b0, 32'h0,        1'b1, 32'h80, 1'b1, 32'h0,  32'h0,        1'b0};
        vecs[10] = '{6'd0, 1'b0, 1'b1, 32'hC0,  1'b0, 32'h0,        1'b1, 32'h80, 1'b1, 32'h0,  32'h0,        1'b0};
        vecs[11] = '{6'd0, 1'b0, 1'b1, 32'hC0,  1'b1, 32'hDEAD_BEEF, 1'b1, 32'h80, 1'b1, 32'h0,  32'h0,        1'b0};
        vecs[12] = '{6'd0, 1'b0, 1'b1, 32'hC0,  1'b0, 32'h0,        1'b0, 32'h80, 1'b1, 32'h0,  32'h0,        1'b0};
        vecs[13] = '{6'd0, 1'b0, 1'b1, 32'hC0,  1'b1, 32'h13,       1'b1, 32'hC0, 1'b0, 32'h0,  32'h0,        1'b0};
        vecs[14] = '{6'd2, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'hC0, 1'b0, 32'hC0, 32'h13,       1'b1};
        vecs[15] = '{6'd2, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'hC0, 1'b0, 32'h0,  32'h0,        1'b0};
        vecs[16] = '{6'd0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,        1'b0, 32'hC0, 1'b1, 32'h0,  32'h0,        1'b0};
        vecs[17] = '{6'd0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hBAD,      1'b0, 32'hC0, 1'b0, 32'h0,  32'h0,        1'b0};
        vecs[18] = '{6'd0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'hC0, 1'b0, 32'h0,  32'h0,        1'b0};

        model_reset();
        do_reset();

        // Directed table: basic fetch, HOLD across stall, flush/discard, bubble, stray ack.
        for (int i = 0; i < NV; i++) begin
            stall = vecs[i].stall; flush = vecs[i].flush; ce_i = vecs[i].ce;
            pc_i = vecs[i].pc; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk1 ($sformatf("vec%0d mem_req", i),  mem_req,  vecs[i].e_req);
            chk32($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            chk1 ($sformatf("vec%0d stallreq", i), stallreq, vecs[i].e_sreq);
            chk32($sformatf("vec%0d id_pc", i),    id_pc,    vecs[i].e_id_pc);
            chk32($sformatf("vec%0d id_inst", i),  id_inst,  vecs[i].e_id_inst);
            chk1 ($sformatf("vec%0d id_valid", i), id_valid, vecs[i].e_id_valid);
            chk1 ($sformatf("vec%0d bus_err", i),  bus_err,  1'b0);
            @(posedge clk); model_tick(); #1;
        end

        // Reset while a fetch is outstanding, then a stray ack in IDLE.
        do_reset();
        stall = 6'h0; flush = 1'b0; ce_i = 1'b1; pc_i = 32'h200; mem_ack = 1'b0;
        run_cycle(1'b1);
        ce_i = 1'b0;
        @(negedge clk);
        chk1("busy mem_req", mem_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); model_tick(); #1;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk1 ("rst-busy mem_req",  mem_req,  1'b0);
        chk32("rst-busy mem_addr", mem_addr, 32'h0);
        chk1 ("rst-busy id_valid", id_valid, 1'b0);
        @(posedge clk); model_tick(); #1;
        mem_ack = 1'b0;
        run_cycle(1'b1);
        chk1("stray ack ignored", mem_req, 1'b0);

        // Randomized traffic against the reference model; ack latency 0..3 cycles.
        do_reset();
        wait_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            stall[0]   = 1'($urandom_range(0, 1));
            stall[1]   = ($urandom_range(0, 3) == 0);
            stall[2]   = ($urandom_range(0, 6) == 0);
            stall[5:3] = 3'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 19) == 0);
            ce_i       = ($urandom_range(0, 9) != 0);
            pc_i       = $urandom() & 32'hFFFF_FFFC;
            mem_rdata  = $urandom();
            if (m_req) begin
                if (wait_cnt == 0) begin
                    mem_ack = 1'b1;
                end else begin
                    mem_ack  = 1'b0;
                    wait_cnt = wait_cnt - 1;
                end
            end else begin
                mem_ack  = ($urandom_range(0, 15) == 0);
                wait_cnt = int'($urandom_range(0, 3));
            end
            run_cycle(1'b1);
        end

`ifdef IFETCH_TIMEOUT_EN
        // No ack ever: abort after 16 BUSY cycles, NOP delivered, one-cycle bus_err.
        do_reset();
        stall = 6'h0; flush = 1'b0; mem_ack = 1'b0; ce_i = 1'b1; pc_i = 32'h300;
        run_cycle(1'b0);
        ce_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk1($sformatf("to wait%0d bus_err", k), bus_err, 1'b0);
            chk1($sformatf("to wait%0d mem_req", k), mem_req, 1'b1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk1 ("timeout bus_err",  bus_err,  1'b1);
        chk1 ("timeout mem_req",  mem_req,  1'b0);
        chk32("timeout id_inst",  id_inst,  32'h0);
        chk32("timeout id_pc",    id_pc,    32'h300);
        chk1 ("timeout id_valid", id_valid, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("timeout pulse end", bus_err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
